// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester, register-file write port and ID scoreboard signals.
// Three requester slots (0 ALU, 1 load, 2 mul/div) arbitrate onto one write port.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req2_valid;
    logic              req2_ready;
    logic [ADDR_W-1:0] req2_addr;
    logic [DATA_W-1:0] req2_data;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    logic              pend_set;
    logic [ADDR_W-1:0] pend_addr;
    logic              rd1_en;
    logic [ADDR_W-1:0] rd1_addr;
    logic              rd2_en;
    logic [ADDR_W-1:0] rd2_addr;
    logic              hazard;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output req2_valid, req2_addr, req2_data,
        output pend_set, pend_addr, rd1_en, rd1_addr, rd2_en, rd2_addr,
        input  req0_ready, req1_ready, req2_ready,
        input  we, waddr, wdata, hazard
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  req2_valid, req2_addr, req2_data,
        input  pend_set, pend_addr, rd1_en, rd1_addr, rd2_en, rd2_addr,
        output req0_ready, req1_ready, req2_ready,
        output we, waddr, wdata, hazard
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter of three one-entry writeback slots onto one regfile write port, plus pending-register scoreboard.
// Latency: transfer edge k -> we high after edge k+1; ready is low while a slot is full; hazard is combinational.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [2:0]        in_valid;
    logic [ADDR_W-1:0] in_addr [3];
    logic [DATA_W-1:0] in_data [3];

    logic [2:0]        full;
    logic [ADDR_W-1:0] slot_addr [3];
    logic [DATA_W-1:0] slot_data [3];
    logic [1:0]        last_grant;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NREG-1:0]   pending;

    logic              gnt_valid;
    logic [1:0]        gnt_idx;
    logic [1:0]        start;

    always_comb begin
        in_valid   = {bus.req2_valid, bus.req1_valid, bus.req0_valid};
        in_addr[0] = bus.req0_addr;
        in_addr[1] = bus.req1_addr;
        in_addr[2] = bus.req2_addr;
        in_data[0] = bus.req0_data;
        in_data[1] = bus.req1_data;
        in_data[2] = bus.req2_data;
    end

    // Search begins just after the previous winner, wrapping modulo 3.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        start     = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        for (int k = 0; k < 3; k++) begin
            logic [1:0] cand;
            cand = start + 2'(k);
            if (cand >= 2'd3) cand = cand - 2'd3;
            if (!gnt_valid && full[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full       <= 3'b000;
            last_grant <= 2'd2;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            pending    <= '0;
            for (int n = 0; n < 3; n++) begin
                slot_addr[n] <= '0;
                slot_data[n] <= '0;
            end
        end else begin
            // A full slot is never ready, so grant-empty and accept are exclusive; zero-register writes are dropped.
            for (int n = 0; n < 3; n++) begin
                if (full[n]) begin
                    if (gnt_valid && gnt_idx == 2'(n)) full[n] <= 1'b0;
                end else if (in_valid[n] && in_addr[n] != '0) begin
                    full[n]      <= 1'b1;
                    slot_addr[n] <= in_addr[n];
                    slot_data[n] <= in_data[n];
                end
            end

            we_q <= gnt_valid;
            if (gnt_valid) begin
                waddr_q    <= slot_addr[gnt_idx];
                wdata_q    <= slot_data[gnt_idx];
                last_grant <= gnt_idx;
            end

            // Set after clear so a same-edge re-issue keeps the register pending.
            if (we_q) pending[waddr_q] <= 1'b0;
            if (bus.pend_set && bus.pend_addr != '0) pending[bus.pend_addr] <= 1'b1;
        end
    end

    always_comb begin
        bus.hazard = (bus.rd1_en && bus.rd1_addr != '0 && pending[bus.rd1_addr] &&
                      !(we_q && waddr_q == bus.rd1_addr)) ||
                     (bus.rd2_en && bus.rd2_addr != '0 && pending[bus.rd2_addr] &&
                      !(we_q && waddr_q == bus.rd2_addr));
    end

    assign bus.req0_ready = ~full[0];
    assign bus.req1_ready = ~full[1];
    assign bus.req2_ready = ~full[2];
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin order, zero register, scoreboard, reset, back-pressure.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.req2_valid = 1'b0; bus.req2_addr = '0; bus.req2_data = '0;
        bus.pend_set = 1'b0; bus.pend_addr = '0;
        bus.rd1_en = 1'b0; bus.rd1_addr = '0;
        bus.rd2_en = 1'b0; bus.rd2_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int q [3][$];
    int dval [3];
    int exp_id;
    int nwr;
    int nacc;
    int id;
    logic [2:0] acc;

    initial begin
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        bus.rd1_en = 1'b1; bus.rd1_addr = 5'd5;
        settle();
        chk("rst_we", bus.we, 0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_ready", {bus.req2_ready, bus.req1_ready, bus.req0_ready}, 3'b111);
        chk("rst_hazard", bus.hazard, 0);
        bus.rd1_en = 1'b0;

        // Single transfer
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h11;
        tick();
        bus.req0_valid = 1'b0;
        chk("single_rdy_low", bus.req0_ready, 0);
        chk("single_we0", bus.we, 0);
        tick();
        chk("single_we", bus.we, 1);
        chk("single_waddr", bus.waddr, 3);
        chk("single_wdata", bus.wdata, 32'h11);
        chk("single_rdy_back", bus.req0_ready, 1);
        tick();
        chk("single_we_off", bus.we, 0);
        chk("single_waddr_hold", bus.waddr, 3);

        // Contention after reset: order 0,1,2, then again starting at 0
        do_reset();
        for (int b = 0; b < 2; b++) begin
            bus.req0_valid = 1'b1; bus.req0_addr = (b == 0) ? 5'd1 : 5'd5; bus.req0_data = 32'hA1 + 32'(b);
            bus.req1_valid = 1'b1; bus.req1_addr = (b == 0) ? 5'd2 : 5'd6; bus.req1_data = 32'hA2 + 32'(b);
            bus.req2_valid = 1'b1; bus.req2_addr = (b == 0) ? 5'd4 : 5'd7; bus.req2_data = 32'hA4 + 32'(b);
            tick();
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.req2_valid = 1'b0;
            chk("cont_rdy_low", {bus.req2_ready, bus.req1_ready, bus.req0_ready}, 3'b000);
            tick();
            chk("cont_w0", {bus.we, bus.waddr}, (b == 0) ? {1'b1, 5'd1} : {1'b1, 5'd5});
            chk("cont_d0", bus.wdata, 32'hA1 + 32'(b));
            tick();
            chk("cont_w1", {bus.we, bus.waddr}, (b == 0) ? {1'b1, 5'd2} : {1'b1, 5'd6});
            tick();
            chk("cont_w2", {bus.we, bus.waddr}, (b == 0) ? {1'b1, 5'd4} : {1'b1, 5'd7});
            chk("cont_d2", bus.wdata, 32'hA4 + 32'(b));
            tick();
            chk("cont_idle", bus.we, 0);
        end

        // Zero register write is accepted and dropped
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hFF;
        tick();
        bus.req1_valid = 1'b0;
        chk("zero_rdy", bus.req1_ready, 1);
        chk("zero_we_a", bus.we, 0);
        tick();
        chk("zero_we_b", bus.we, 0);
        tick();
        chk("zero_we_c", bus.we, 0);

        // Scoreboard
        bus.rd1_en = 1'b1; bus.rd1_addr = 5'd7;
        for (int r = 0; r < 2; r++) begin
            bus.pend_set = 1'b1; bus.pend_addr = 5'd7;
            tick();
            bus.pend_set = 1'b0;
            settle();
            chk("sb_hazard_set", bus.hazard, 1);
            bus.req2_valid = 1'b1; bus.req2_addr = 5'd7; bus.req2_data = 32'h77 + 32'(r);
            tick();
            bus.req2_valid = 1'b0;
            settle();
            chk("sb_hazard_slot", bus.hazard, 1);
            tick();
            chk("sb_we", {bus.we, bus.waddr}, {1'b1, 5'd7});
            chk("sb_hazard_bypass", bus.hazard, 0);
            if (r == 1) begin
                bus.pend_set = 1'b1; bus.pend_addr = 5'd7;
            end
            tick();
            bus.pend_set = 1'b0;
            settle();
            chk("sb_hazard_after", bus.hazard, (r == 1) ? 1 : 0);
        end
        bus.rd1_en = 1'b0;

        // Reset mid-operation
        bus.rd2_en = 1'b1; bus.rd2_addr = 5'd5;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd8; bus.req0_data = 32'h88;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h99;
        bus.pend_set = 1'b1; bus.pend_addr = 5'd5;
        tick();
        idle_inputs();
        bus.rd2_en = 1'b1; bus.rd2_addr = 5'd5;
        settle();
        chk("mid_full", {bus.req1_ready, bus.req0_ready}, 2'b00);
        chk("mid_hazard_pre", bus.hazard, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_we", bus.we, 0);
        chk("mid_ready", {bus.req2_ready, bus.req1_ready, bus.req0_ready}, 3'b111);
        chk("mid_hazard", bus.hazard, 0);
        tick();
        chk("mid_we_after", bus.we, 0);
        bus.rd2_en = 1'b0;

        // Back-pressure: all requesters valid every cycle; expect strict 0,1,2 rotation, no loss
        do_reset();
        exp_id = 0; nwr = 0; nacc = 0;
        for (int n = 0; n < 3; n++) dval[n] = 32'h1000 * (n + 1);
        bus.req0_addr = 5'd10; bus.req1_addr = 5'd11; bus.req2_addr = 5'd12;
        for (int i = 0; i < 40; i++) begin
            bus.req0_valid = (i < 30); bus.req1_valid = (i < 30); bus.req2_valid = (i < 30);
            bus.req0_data = dval[0]; bus.req1_data = dval[1]; bus.req2_data = dval[2];
            settle();
            acc = {bus.req2_valid & bus.req2_ready, bus.req1_valid & bus.req1_ready,
                   bus.req0_valid & bus.req0_ready};
            for (int n = 0; n < 3; n++) begin
                if (acc[n]) begin
                    q[n].push_back(dval[n]);
                    dval[n]++;
                    nacc++;
                end
            end
            tick();
            if (bus.we) begin
                id = int'(bus.waddr) - 10;
                nwr++;
                chk("bp_order", 64'(id), 64'(exp_id));
                exp_id = (exp_id + 1) % 3;
                if (id >= 0 && id < 3 && q[id].size() > 0) begin
                    chk("bp_data", bus.wdata, 64'(q[id].pop_front()));
                end else begin
                    chk("bp_unexpected_write", 1'b1, 1'b0);
                end
            end
        end
        chk("bp_q0_empty", 64'(q[0].size()), 0);
        chk("bp_q1_empty", 64'(q[1].size()), 0);
        chk("bp_q2_empty", 64'(q[2].size()), 0);
        chk("bp_write_count", 64'(nwr), 64'(nacc));
        chk("bp_enough_writes", (nwr >= 27), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL use parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL use parameter ADDR_W, default 5, meaning register address width (2^ADDR_W registers).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 reqN_valid  input  1  writeback request from requester N (N = 0 ALU, 1 load, 2 mul/div).
REQ-006 reqN_ready  output  1  requester N holding slot empty; registered, no combinational path from any input.
REQ-007 reqN_addr  input  ADDR_W  destination register of requester N.
REQ-008 reqN_data  input  DATA_W  writeback data of requester N.
REQ-009 we  output  1  register file write enable; registered.
REQ-010 waddr  output  ADDR_W  register file write address; registered.
REQ-011 wdata  output  DATA_W  register file write data; registered.
REQ-012 pend_set  input  1  ID issues a long-latency op; marks pend_addr pending.
REQ-013 pend_addr  input  ADDR_W  destination register to mark pending.
REQ-014 rd1_en, rd2_en  input  1 each  ID read-port enables.
REQ-015 rd1_addr, rd2_addr  input  ADDR_W each  ID read addresses.
REQ-016 hazard  output  1  ID must stall; combinational.

Function
REQ-017 Handshake: transfer on requester N when reqN_valid && reqN_ready at a rising edge; slot N captures addr/data, reqN_ready deasserts next cycle.
REQ-018 A transfer with reqN_addr == 0 SHALL be accepted and discarded: slot stays empty, no write issued.
REQ-019 Each cycle, among full slots, one winner SHALL be chosen round-robin: search starts at (last_grant+1) mod 3; last_grant updates only on a grant.
REQ-020 On a grant, winner's addr/data SHALL load into waddr/wdata with we=1 at the next edge, and winner's slot SHALL empty at the same edge (reqN_ready high the following cycle).
REQ-021 With no full slot, we SHALL be 0 the next cycle; waddr/wdata hold their previous values.
REQ-022 Latency: transfer at edge k -> we high in cycle after edge k+1 at earliest -> regfile write at edge k+2; with all three slots full, worst case 3 cycles per slot.
REQ-023 A slot SHALL NOT accept a new transfer in the cycle it is being granted (ready is registered, low while full).
REQ-024 Scoreboard: one pending bit per register; pend_set with pend_addr != 0 sets bit at next edge; pend_addr == 0 ignored.
REQ-025 Pending bit for waddr SHALL clear at the edge ending a cycle with we=1; if pend_set targets the same address at that edge, set wins.
REQ-026 hazard = OR over ports p of (rdp_en && rdp_addr != 0 && pending[rdp_addr] && !(we && waddr == rdp_addr)); the we term covers same-cycle regfile bypass.
REQ-027 Write ordering between slots holding the same address is round-robin order only; requesters SHALL NOT issue two in-flight writes to one register.

Reset
REQ-028 While rst=1 at an edge: all slots empty, reqN_ready=1 from next cycle, we=0, waddr=0, wdata=0, last_grant=2 (requester 0 first), all pending bits 0.
REQ-029 Reset asserted mid-operation SHALL discard slot contents and pending bits with no write issued; hazard=0 while pending is clear.

Verification
REQ-030 Single: req0 addr=3 data=0x11 at edge 0 -> we=1 waddr=3 wdata=0x11 in cycle after edge 1, req0_ready low exactly one cycle.
REQ-031 Contention: all three valid same edge (addrs 1,2,4) after reset -> writes in order req0, req1, req2 on consecutive cycles; next burst starts at req0 again with new last_grant=2.
REQ-032 Zero reg: req1 addr=0 data=0xFF -> handshake completes, we never asserted, slot ready next cycle.
REQ-033 Scoreboard: pend_set addr=7; rd1_en addr=7 -> hazard=1; req2 writes addr=7 -> hazard=0 in the we cycle and after; simultaneous pend_set addr=7 with that write -> hazard=1 again next cycle.
REQ-034 Reset mid-op: two slots full, pending bit 5 set, assert rst one cycle -> no we, all ready=1, hazard=0 for rd addr 5.
REQ-035 Back-pressure: req0 valid every cycle with slots 1,2 kept full -> req0 receives exactly one grant in every three write cycles, no data loss or duplication.
